sequence_display: RTL and testbench
===================================

# sequence_display

Producer side of the level-display handshake for the memory-sequence game. On a level start it fetches the stored 20-bit sequence word from the sequence RAM and presents the first LVL 4-bit digits one at a time, each for a fixed on-time followed by a blank gap. It then pulses display_done, which releases the player-input checker. It sits between the level controller, the sequence RAM and the seven-segment digit driver.

## Interface
- ON_CYCLES, 4: clock cycles each digit is shown (≥1).
- OFF_CYCLES, 2: blank cycles after each digit (≥1).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  level-start pulse; sampled only in IDLE.
- LVL  in  3  number of digits to show; 0 shows none; 6–7 are clamped to 5.
- S_in  in  20  RAM read data; digit 1 = S_in[19:16], digit 5 = S_in[3:0].
- replay  in  1  re-show the cached sequence; ignored unless SEQ_DISP_REPLAY_EN.
- RAM_addr  out  5  RAM address; always 0.
- RAM_r  out  1  one-cycle read strobe.
- digit  out  4  current digit value; 0 when digit_valid=0.
- digit_valid  out  1  high while a digit is on.
- busy  out  1  high in every state except IDLE.
- display_done  out  1  one-cycle pulse at the end of the display.

## Operation
- All outputs are registered. Reset values of all outputs and of the internal counters and sequence register: 0. State after reset: IDLE.
- States: IDLE, FETCH, WAIT1, WAIT2, CATCH, SHOW, GAP, DONE.
- IDLE → FETCH on start=1. RAM_r←1 and RAM_addr←0 on the same edge.
- FETCH → WAIT1 (RAM_r←0) → WAIT2 → CATCH.
- CATCH: seq←S_in, idx←0, n←min(LVL,5), with LVL sampled on this edge. Next state is SHOW if n≠0, otherwise DONE.
- SHOW: digit←seq nibble idx (MSB nibble first) and digit_valid←1 for exactly ON_CYCLES cycles, then → GAP.
- GAP: digit←0 and digit_valid←0 for OFF_CYCLES cycles. idx←idx+1 on exit. The next state is SHOW if idx+1<n, otherwise DONE.
- DONE: display_done←1 for one cycle, then → IDLE.
- start while busy is ignored; no queuing.
- LVL changes after CATCH have no effect on the run in progress.
- Reset mid-operation aborts immediately. All outputs go to 0 and no display_done is produced.
- The cycle counter is sized to hold max(ON_CYCLES, OFF_CYCLES) and cleared on every state entry. idx is 3 bits.

## Timing
- start sampled at edge E0 → RAM_r high in cycle E0–E1; S_in is captured at edge E3.
- The first digit is visible from E4.
- display_done is high in the cycle after edge E4 + n·(ON_CYCLES+OFF_CYCLES).
- For n=0, display_done is high after edge E4.
- busy is high from E0 until the edge where display_done falls.
- The RAM returns valid data within 3 cycles of the RAM_r rising edge and holds it until CATCH.

## Configuration
- SEQ_DISP_REPLAY_EN defined:
  - replay=1 in IDLE with a valid cache (at least one completed fetch since reset) → CATCH-equivalent load from the cached seq, then SHOW/DONE. No RAM read is issued.
  - Latency: digits start 1 cycle after the replay edge.
  - If start and replay are both high, start wins.
- Undefined: replay is ignored and the cache-valid flag is not implemented. The block behaves exactly as described in Operation.

## Structure
- Shared package seq_game_pkg holds:
  - MAX_LVL=5, NIBBLE_W=4, SEQ_W=20, RAM_ADDR_W=5;
  - the sequence_display state enum;
  - a nibble-select function shared with the checker.
- One sub-module, seq_disp_timer: loadable down-counter with a terminal-count flag, used for both the on-time and the gap.

## Test plan
- Default parameters, LVL=3, S_in=20'hA5C3E, start pulse:
  - RAM_r high for exactly 1 cycle;
  - digit shows A,5,C, each for 4 cycles with 2-cycle blanks;
  - display_done pulses once, 22 cycles after the start edge.
- LVL=0 → no digit_valid; display_done 4 cycles after start; busy low the cycle after.
- LVL=7, S_in=20'h12345 → digits 1,2,3,4,5 shown (clamped to 5).
- start re-pulsed during SHOW, and LVL changed mid-run → no second RAM_r; digit count unchanged.
- rst=0 during the second digit → all outputs 0 next cycle; no display_done; a fresh start works normally.
- With SEQ_DISP_REPLAY_EN, after a run with S_in=20'h98765, LVL=2:
  - S_in changed, then replay → shows 9,8 with no RAM_r;
  - replay straight after reset → ignored.

Source files
------------

// File: rtl/seq_game_pkg.sv
// Shared definitions for the memory-sequence game: widths, display FSM states
// and the nibble selector used by both the display and the player-input checker.
package seq_game_pkg;

  localparam int unsigned MAX_LVL    = 5;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned SEQ_W      = 20;
  localparam int unsigned RAM_ADDR_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT1,
    S_WAIT2,
    S_CATCH,
    S_SHOW,
    S_GAP,
    S_DONE
  } disp_state_t;

  // Digit idx of the sequence word, digit 0 in the most significant nibble.
  function automatic logic [NIBBLE_W-1:0] nibble_sel(input logic [SEQ_W-1:0] seq,
                                                     input logic [2:0]       idx);
    logic [SEQ_W-1:0] sh;
    sh = '0;
    if (idx < 3'(MAX_LVL)) begin
      sh = seq >> (NIBBLE_W * (MAX_LVL - 1 - 32'(idx)));
    end
    return sh[NIBBLE_W-1:0];
  endfunction

endpackage

// File: rtl/seq_disp_timer.sv
// Loadable down-counter with terminal-count flag; times both digit on-time and gap.
module seq_disp_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/sequence_display.sv
// Level-display producer: fetches the sequence word and shows the first LVL digits
// with on/gap timing, then pulses display_done. Replay of the cached word: SEQ_DISP_REPLAY_EN.
module sequence_display
  import seq_game_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned OFF_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            LVL,
  input  logic [SEQ_W-1:0]      S_in,
  input  logic                  replay,
  output logic [RAM_ADDR_W-1:0] RAM_addr,
  output logic                  RAM_r,
  output logic [NIBBLE_W-1:0]   digit,
  output logic                  digit_valid,
  output logic                  busy,
  output logic                  display_done
);

  localparam int unsigned CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  disp_state_t         state, state_d;
  logic [SEQ_W-1:0]    seq, seq_d;
  logic [2:0]          idx, idx_d;
  logic [2:0]          n, n_d;
  logic [2:0]          n_lvl;
  logic                ram_r_d;
  logic [NIBBLE_W-1:0] digit_d;
  logic                tmr_load, tmr_tc;
  logic [CNT_W-1:0]    tmr_val;

  assign n_lvl = (LVL > 3'(MAX_LVL)) ? 3'(MAX_LVL) : LVL;

`ifdef SEQ_DISP_REPLAY_EN
  logic cache_vld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cache_vld <= 1'b0;
    end else if (state == S_WAIT2) begin
      cache_vld <= 1'b1;
    end
  end
`else
  logic unused_replay;
  assign unused_replay = replay;
`endif

  always_comb begin
    state_d = state;
    seq_d   = seq;
    idx_d   = idx;
    n_d     = n;
    ram_r_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          ram_r_d = 1'b1;
        end
`ifdef SEQ_DISP_REPLAY_EN
        // Replay skips the RAM and enters CATCH directly, keeping the cached word.
        else if (replay && cache_vld) begin
          state_d = S_CATCH;
          idx_d   = '0;
          n_d     = n_lvl;
        end
`endif
      end
      S_FETCH: state_d = S_WAIT1;
      S_WAIT1: state_d = S_WAIT2;
      S_WAIT2: begin
        state_d = S_CATCH;
        seq_d   = S_in;
        idx_d   = '0;
        n_d     = n_lvl;
      end
      S_CATCH: state_d = (n != '0) ? S_SHOW : S_DONE;
      S_SHOW:  if (tmr_tc) state_d = S_GAP;
      S_GAP: begin
        if (tmr_tc) begin
          idx_d   = idx + 3'd1;
          state_d = (idx_d < n) ? S_SHOW : S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they change on the transition edge.
    digit_d  = (state_d == S_SHOW) ? nibble_sel(seq_d, idx_d) : '0;
    tmr_load = (state_d != state);
    tmr_val  = (state_d == S_SHOW) ? CNT_W'(ON_CYCLES - 1)  :
               (state_d == S_GAP)  ? CNT_W'(OFF_CYCLES - 1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      seq          <= '0;
      idx          <= '0;
      n            <= '0;
      RAM_addr     <= '0;
      RAM_r        <= 1'b0;
      digit        <= '0;
      digit_valid  <= 1'b0;
      busy         <= 1'b0;
      display_done <= 1'b0;
    end else begin
      state        <= state_d;
      seq          <= seq_d;
      idx          <= idx_d;
      n            <= n_d;
      RAM_addr     <= '0;
      RAM_r        <= ram_r_d;
      digit        <= digit_d;
      digit_valid  <= (state_d == S_SHOW);
      busy         <= (state_d != S_IDLE);
      display_done <= (state_d == S_DONE);
    end
  end

  seq_disp_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

endmodule

// File: tb/tb_sequence_display.sv
// Directed self-checking bench for sequence_display; replay scenarios follow SEQ_DISP_REPLAY_EN.
module tb_sequence_display;

  localparam int unsigned ON  = 4;
  localparam int unsigned OFF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        replay = 1'b0;
  logic [2:0]  LVL = '0;
  logic [19:0] S_in = '0;
  logic [4:0]  RAM_addr;
  logic        RAM_r;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        busy;
  logic        display_done;
  logic [12:0] obs;

  int total = 0;
  int bad   = 0;

  sequence_display #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .LVL          (LVL),
    .S_in         (S_in),
    .replay       (replay),
    .RAM_addr     (RAM_addr),
    .RAM_r        (RAM_r),
    .digit        (digit),
    .digit_valid  (digit_valid),
    .busy         (busy),
    .display_done (display_done)
  );

  always #5 clk = ~clk;

  // {RAM_addr, RAM_r, busy, digit_valid, digit, display_done}
  assign obs = {RAM_addr, RAM_r, busy, digit_valid, digit, display_done};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs k cycles after the start (or replay) edge.
  function automatic logic [12:0] exp_out(int k, int n, logic [19:0] seq, bit rep);
    int          first, done_k, p;
    logic        v, rr, bsy, dn;
    logic [3:0]  d;
    logic [19:0] s;
    first  = rep ? 1 : 4;
    done_k = first + n * int'(ON + OFF);
    rr     = (k == 0) && !rep;
    bsy    = (k <= done_k);
    dn     = (k == done_k);
    v      = 1'b0;
    d      = '0;
    if (k >= first && k < done_k) begin
      p = k - first;
      if (p % int'(ON + OFF) < int'(ON)) begin
        v = 1'b1;
        s = seq << (4 * (p / int'(ON + OFF)));
        d = s[19:16];
      end
    end
    return {5'd0, rr, bsy, v, d, dn};
  endfunction

  task automatic test_reset;
    rst   = 1'b0;
    start = 1'b1;
    LVL   = 3'd3;
    for (int k = 0; k < 4; k++) begin
      tick;
      total++;
      if (obs !== 13'd0) begin
        bad++;
        $display("FAIL reset k=%0d actual=%h required=%h", k, obs, 13'd0);
      end
    end
    start = 1'b0;
    rst   = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    LVL   = 3'd3;
    S_in  = 20'hA5C3E;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) tick;
      total++;
      if (obs !== exp_out(k, 3, 20'hA5C3E, 1'b0)) begin
        bad++;
        $display("FAIL basic k=%0d actual=%h required=%h", k, obs, exp_out(k, 3, 20'hA5C3E, 1'b0));
      end
    end
  endtask

  task automatic test_lvl_zero;
    LVL   = 3'd0;
    S_in  = 20'hFFFFF;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick;
      total++;
      if (obs !== exp_out(k, 0, 20'hFFFFF, 1'b0)) begin
        bad++;
        $display("FAIL lvl_zero k=%0d actual=%h required=%h", k, obs, exp_out(k, 0, 20'hFFFFF, 1'b0));
      end
    end
  endtask

  task automatic test_clamp;
    LVL   = 3'd7;
    S_in  = 20'h12345;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= 37; k++) begin
      if (k > 0) tick;
      total++;
      if (obs !== exp_out(k, 5, 20'h12345, 1'b0)) begin
        bad++;
        $display("FAIL clamp k=%0d actual=%h required=%h", k, obs, exp_out(k, 5, 20'h12345, 1'b0));
      end
    end
  endtask

  task automatic test_busy_ignore;
    LVL   = 3'd2;
    S_in  = 20'h6789A;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick;
      total++;
      if (obs !== exp_out(k, 2, 20'h6789A, 1'b0)) begin
        bad++;
        $display("FAIL busy_ignore k=%0d actual=%h required=%h", k, obs, exp_out(k, 2, 20'h6789A, 1'b0));
      end
      if (k == 3) S_in = 20'h00000;
      if (k == 4) LVL = 3'd5;
      start = (k == 5);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid;
    LVL   = 3'd3;
    S_in  = 20'hA5C3E;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) tick;
      total++;
      if (obs !== exp_out(k, 3, 20'hA5C3E, 1'b0)) begin
        bad++;
        $display("FAIL reset_mid_pre k=%0d actual=%h required=%h", k, obs, exp_out(k, 3, 20'hA5C3E, 1'b0));
      end
    end
    rst = 1'b0;
    tick;
    total++;
    if (obs !== 13'd0) begin
      bad++;
      $display("FAIL reset_mid_abort actual=%h required=%h", obs, 13'd0);
    end
    rst = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick;
      total++;
      if (obs !== 13'd0) begin
        bad++;
        $display("FAIL reset_mid_quiet k=%0d actual=%h required=%h", k, obs, 13'd0);
      end
    end
    LVL   = 3'd1;
    S_in  = 20'hF0000;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) tick;
      total++;
      if (obs !== exp_out(k, 1, 20'hF0000, 1'b0)) begin
        bad++;
        $display("FAIL reset_mid_fresh k=%0d actual=%h required=%h", k, obs, exp_out(k, 1, 20'hF0000, 1'b0));
      end
    end
  endtask

`ifdef SEQ_DISP_REPLAY_EN
  task automatic test_replay;
    rst = 1'b0;
    tick;
    rst    = 1'b1;
    replay = 1'b1;
    LVL    = 3'd2;
    tick;
    replay = 1'b0;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (obs !== 13'd0) begin
        bad++;
        $display("FAIL replay_no_cache k=%0d actual=%h required=%h", k, obs, 13'd0);
      end
      tick;
    end
    S_in  = 20'h98765;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) tick;
      total++;
      if (obs !== exp_out(k, 2, 20'h98765, 1'b0)) begin
        bad++;
        $display("FAIL replay_fetch k=%0d actual=%h required=%h", k, obs, exp_out(k, 2, 20'h98765, 1'b0));
      end
    end
    S_in   = 20'h11111;
    replay = 1'b1;
    tick;
    replay = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) tick;
      total++;
      if (obs !== exp_out(k, 2, 20'h98765, 1'b1)) begin
        bad++;
        $display("FAIL replay_show k=%0d actual=%h required=%h", k, obs, exp_out(k, 2, 20'h98765, 1'b1));
      end
    end
  endtask
`else
  task automatic test_replay;
    replay = 1'b1;
    tick;
    replay = 1'b0;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (obs !== 13'd0) begin
        bad++;
        $display("FAIL replay_ignored k=%0d actual=%h required=%h", k, obs, 13'd0);
      end
      tick;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_lvl_zero;
    test_clamp;
    test_busy_ignore;
    test_reset_mid;
    test_replay;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
